// File: rtl/spif_pkt_pkg.sv
// Packet field layout and the per-field key mapping helper for mc_pkt_assembler.
package spif_pkt_pkg;
  localparam int HDR_W      = 8;
  localparam int KEY_W      = 32;
  localparam int PLD_W      = 32;
  localparam int PKT_W      = PLD_W + KEY_W + HDR_W;
  localparam int SFT_W      = 6;
  localparam int PARITY_BIT = 0;
  localparam int PLD_BIT    = 1;
  localparam int KEY_LSB    = 8;
  localparam int PLD_LSB    = 40;

  // Negative shifts are 6-bit two's complement; the 5-bit magnitude wraps, so 6'h20 shifts by 0.
  function automatic logic [KEY_W-1:0] map_field(input logic [31:0] evt,
                                                 input logic [31:0] msk,
                                                 input logic [SFT_W-1:0] sft);
    logic [31:0] m;
    logic [4:0]  lsh;
    m   = evt & msk;
    lsh = ~sft[4:0] + 5'd1;
    return sft[5] ? (m << lsh) : (m >> sft[4:0]);
  endfunction
endpackage

// File: rtl/evt_key_mapper.sv
// Combinational event-to-key mapper: base key OR'ed with every masked/shifted field.
module evt_key_mapper
  import spif_pkt_pkg::*;
#(
  parameter int NUM_MREGS = 4
) (
  input  logic [KEY_W-1:0]                  key_base,
  input  logic [31:0]                       evt_data,
  input  logic [NUM_MREGS-1:0][31:0]        field_msk,
  input  logic [NUM_MREGS-1:0][SFT_W-1:0]   field_sft,
  output logic [KEY_W-1:0]                  key
);
  always_comb begin
    key = key_base;
    for (int i = 0; i < NUM_MREGS; i++)
      key = key | map_field(evt_data, field_msk[i], field_sft[i]);
  end
endmodule

// File: rtl/mc_pkt_assembler.sv
// Round-robin event arbiter, key mapper and 2-entry packet FIFO.
// Define PKT_ASSEMBLER_PAYLOAD_EN to carry a free-running timestamp as payload.
module mc_pkt_assembler
  import spif_pkt_pkg::*;
#(
  parameter int PACKET_BITS  = 72,
  parameter int NUM_MREGS    = 4,
  parameter int NUM_CHANNELS = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CHANNELS-1:0][31:0]       mp_key_in,
  input  logic [NUM_MREGS-1:0][31:0]          field_msk_in,
  input  logic [NUM_MREGS-1:0][SFT_W-1:0]     field_sft_in,
  input  logic [NUM_CHANNELS-1:0][31:0]       evt_data_in,
  input  logic [NUM_CHANNELS-1:0]             evt_vld_in,
  output logic [NUM_CHANNELS-1:0]             evt_rdy_out,
  output logic [PACKET_BITS-1:0]              pkt_data_out,
  output logic                                pkt_vld_out,
  input  logic                                pkt_rdy_in,
  output logic [31:0]                         pkt_cnt_out
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [CH_W-1:0]                  rr_ptr, gnt_idx;
  logic                             gnt_any, push, pop;
  logic [1:0]                       cnt;
  logic                             rd_ptr, wr_ptr;
  logic [1:0][PACKET_BITS-1:0]      mem;
  logic [KEY_W-1:0]                 key;
  logic [PLD_W-1:0]                 payload;
  logic                             pld_flag;
  logic [HDR_W-1:0]                 hdr;
  logic [PACKET_BITS-1:0]           pkt_w;

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CHANNELS;
      if (!gnt_any && evt_vld_in[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    evt_rdy_out = '0;
    if (gnt_any && cnt < 2'd2 && !reset) evt_rdy_out[gnt_idx] = 1'b1;
  end

  assign push = |evt_rdy_out;
  assign pop  = (cnt != 2'd0) && pkt_rdy_in;

  evt_key_mapper #(.NUM_MREGS(NUM_MREGS)) u_mapper (
    .key_base  (mp_key_in[gnt_idx]),
    .evt_data  (evt_data_in[gnt_idx]),
    .field_msk (field_msk_in),
    .field_sft (field_sft_in),
    .key       (key)
  );

`ifdef PKT_ASSEMBLER_PAYLOAD_EN
  logic [31:0] ts;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + 32'd1;
  end
  assign payload  = ts;
  assign pld_flag = 1'b1;
`else
  assign payload  = '0;
  assign pld_flag = 1'b0;
`endif

  // Header bits other than the flag are zero, so parity only needs payload, key and flag.
  always_comb begin
    hdr              = '0;
    hdr[PLD_BIT]     = pld_flag;
    hdr[PARITY_BIT]  = ~^{payload, key, pld_flag};
  end
  assign pkt_w = PACKET_BITS'({payload, key, hdr});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      mem         <= '0;
      rr_ptr      <= '0;
      pkt_cnt_out <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pkt_w;
        wr_ptr      <= ~wr_ptr;
        rr_ptr      <= (gnt_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + CH_W'(1);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
      if (pop && pkt_cnt_out != 32'hFFFF_FFFF) pkt_cnt_out <= pkt_cnt_out + 32'd1;
    end
  end

  assign pkt_data_out = mem[rd_ptr];
  assign pkt_vld_out  = (cnt != 2'd0);
endmodule

// File: doc/mc_pkt_assembler.md
MC_PKT_ASSEMBLER -- requirements
Module: mc_pkt_assembler

Interface
REQ-001 Parameter PACKET_BITS, default 72: width of the packet output.
REQ-002 Parameter NUM_MREGS, default 4: number of field mask/shift register pairs.
REQ-003 Parameter NUM_CHANNELS, default 2 (range 1..8): number of event input channels.
REQ-004 Port clk, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port mp_key_in, input, 32 x NUM_CHANNELS: mapping base key, one per channel.
REQ-007 Port field_msk_in, input, 32 x NUM_MREGS: field masks, shared by all channels.
REQ-008 Port field_sft_in, input, 6 x NUM_MREGS: signed field shifts, shared by all channels.
REQ-009 Port evt_data_in, input, 32 x NUM_CHANNELS: event data, one word per channel.
REQ-010 Port evt_vld_in, input, NUM_CHANNELS: per-channel event valid.
REQ-011 Port evt_rdy_out, output, NUM_CHANNELS: per-channel event ready.
REQ-012 Port pkt_data_out, output, PACKET_BITS: assembled packet, laid out as {payload[71:40], key[39:8], header[7:0]}.
REQ-013 Port pkt_vld_out, output, 1: packet valid.
REQ-014 Port pkt_rdy_in, input, 1: packet ready.
REQ-015 Port pkt_cnt_out, output, 32: count of packets transferred.

Function
REQ-016 Mapping: key = mp_key_in[c] OR'ed with each field i.
- Field i = (evt & msk[i]) >> sft[i][4:0] when sft[i][5] = 0.
- Field i = (evt & msk[i]) << ((~sft[i][4:0]) + 1) (5-bit) when sft[i][5] = 1.
REQ-017 Input transfer on channel c: the cycle in which evt_vld_in[c] && evt_rdy_out[c] are both high.
REQ-018 At most one evt_rdy_out bit is high per cycle, and only while the output FIFO count < 2.
REQ-019 evt_rdy_out is combinational from the registered FIFO count, the round-robin pointer and evt_vld_in.
- The ready bit goes to the first valid channel at or after the pointer, scanning upward modulo NUM_CHANNELS.
REQ-020 After a transfer on channel c, the pointer becomes (c+1) mod NUM_CHANNELS; with no transfer, the pointer holds.
REQ-021 Output buffer: 2-entry FIFO of complete packets.
- An accepted event is written to the FIFO in the transfer cycle.
- A packet is popped in any cycle with pkt_vld_out && pkt_rdy_in.
- A simultaneous push and pop at count 1 leaves the count at 1.
REQ-022 Latency: an event accepted into an empty FIFO appears on pkt_data_out with pkt_vld_out high on the next cycle.
REQ-023 pkt_vld_out = (count != 0); pkt_data_out is the FIFO head and stays stable while pkt_vld_out && !pkt_rdy_in.
REQ-024 Packets leave in acceptance order; no event is ever dropped or duplicated.
REQ-025 Header: bits [7:2] = 0; bit 1 = payload-present flag (REQ-030); bit 0 = parity.
- Bit 0 is chosen so that the whole 72-bit packet has odd parity.
REQ-026 pkt_cnt_out increments by 1 on each output transfer and saturates at 32'hFFFF_FFFF.

Reset
REQ-027 While reset is high, the block holds:
- evt_rdy_out = 0, pkt_vld_out = 0, pkt_data_out = 0, pkt_cnt_out = 0;
- FIFO empty, pointer = 0, timestamp = 0.
REQ-028 A reset asserted mid-operation discards all buffered packets.
- The first cycle after release accepts input normally.

Configuration
REQ-029 Macro PKT_ASSEMBLER_PAYLOAD_EN controls the timestamp payload.
REQ-030 With the macro defined:
- a 32-bit free-running timestamp increments every cycle and wraps from FFFF_FFFF to 0;
- payload = timestamp value in the transfer cycle;
- header bit 1 = 1.
REQ-031 With the macro undefined: payload = 0, header bit 1 = 0, and no timestamp register exists.

Structure
REQ-032 Package spif_pkt_pkg holds:
- header bit positions (PARITY_BIT = 0, PLD_BIT = 1);
- KEY_LSB = 8, PLD_LSB = 40;
- the packet field widths.
REQ-033 Sub-module evt_key_mapper: combinational mapper per REQ-016.
- One instance, fed by the granted channel's data and key.

Verification
REQ-034 Single event: ch0 key=0x8000_0000, msk0=0xFF, sft0=0, others 0; data 0x12 -> next cycle key 0x8000_0012, header parity correct, pkt_cnt_out=1.
REQ-035 Negative shift: sft0=6'h3C (left 4), msk0=0xF, data 0x5 -> key bits [7:4] = 0x5.
REQ-036 Fairness: both channels valid continuously, pkt_rdy_in=1 -> grants alternate 0,1,0,1 and output order matches grant order.
REQ-037 Backpressure: pkt_rdy_in=0 for 5 cycles with ch0 valid -> exactly 2 accepted, evt_rdy_out=0 and pkt_data_out stable, all drained in order on release.
REQ-038 Reset asserted with 2 packets buffered -> pkt_vld_out=0 and pkt_cnt_out=0 immediately, no stale packet after release.
REQ-039 Payload macro: run with PKT_ASSEMBLER_PAYLOAD_EN defined -> payload equals the transfer-cycle timestamp and header bit 1 = 1; run undefined -> payload 0 and bit 1 = 0.
